// File: rtl/hdmi_pixel_packer.sv
// HDMI capture stage: samples RGB888 pixels during DE, packs 4 pixels into 3 little-endian
// 32-bit words tagged with sof/eol, and buffers them in a show-ahead FIFO for the DDR writer.
module hdmi_pixel_packer #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned MAX_WIDTH_BITS = 12
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_clr_status,
    input  logic [23:0]               i_hdmi_data,
    input  logic                      i_hdmi_hs,
    input  logic                      i_hdmi_vs,
    input  logic                      i_hdmi_de,
    output logic [31:0]               o_out_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic                      o_out_sof,
    output logic                      o_out_eol,
    output logic                      o_busy,
    output logic                      o_overflow,
    output logic [MAX_WIDTH_BITS-1:0] o_line_width,
    output logic [MAX_WIDTH_BITS-1:0] o_line_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);
    localparam logic [MAX_WIDTH_BITS-1:0] CNT_MAX = '1;

    typedef enum logic {StIdle, StActive} state_e;

    state_e                    r_state;
    logic [23:0]               r_data, r_stash;
    logic                      r_hs, r_vs, r_vs_d, r_de, r_de_d;
    logic [1:0]                r_phase;
    logic                      r_sof_arm, r_overflow;
    logic [MAX_WIDTH_BITS-1:0] r_px_cnt, r_line_cnt, r_line_width, r_line_count;
    logic [33:0]               r_mem [FIFO_DEPTH];
    logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
    logic [AW:0]               r_count;

    logic                      w_vs_rise, w_vs_fall, w_pix, w_line_end, w_last_pix;
    logic                      w_wr, w_eol, w_rd, w_full, w_push, w_drop, w_unused;
    logic [31:0]               w_word;
    logic [23:0]               w_stash_d;
    logic [1:0]                w_phase_d;
    logic [MAX_WIDTH_BITS-1:0] w_px_cnt_inc, w_line_cnt_inc;

    assign w_unused   = r_hs;
    assign w_vs_rise  = r_vs & ~r_vs_d;
    assign w_vs_fall  = ~r_vs & r_vs_d;
    assign w_pix      = (r_state == StActive) & r_de;
    assign w_line_end = (r_state == StActive) & ~r_de & r_de_d;
    // Look one pixel ahead so a word-aligned last word can carry eol without extra latency.
    assign w_last_pix = w_pix & ~i_hdmi_de;

    assign w_px_cnt_inc   = (r_px_cnt == CNT_MAX) ? r_px_cnt : r_px_cnt + MAX_WIDTH_BITS'(1);
    assign w_line_cnt_inc = (r_line_cnt == CNT_MAX) ? r_line_cnt
                                                    : r_line_cnt + MAX_WIDTH_BITS'(1);

    // vs history resets high so a vs already high at reset release is not taken as a rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_hs   <= 1'b0;
            r_vs   <= 1'b1;
            r_vs_d <= 1'b1;
            r_de   <= 1'b0;
            r_de_d <= 1'b0;
        end else begin
            r_data <= i_hdmi_data;
            r_hs   <= i_hdmi_hs;
            r_vs   <= i_hdmi_vs;
            r_vs_d <= r_vs;
            r_de   <= i_hdmi_de;
            r_de_d <= r_de;
        end
    end

    always_comb begin
        w_wr      = 1'b0;
        w_eol     = 1'b0;
        w_word    = '0;
        w_stash_d = r_stash;
        w_phase_d = r_phase;
        if (w_pix) begin
            w_phase_d = r_phase + 2'd1;
            case (r_phase)
                2'd0: w_stash_d = r_data;
                2'd1: begin
                    w_wr      = 1'b1;
                    w_word    = {r_data[7:0], r_stash};
                    w_stash_d = {8'h00, r_data[23:8]};
                end
                2'd2: begin
                    w_wr      = 1'b1;
                    w_word    = {r_data[15:0], r_stash[15:0]};
                    w_stash_d = {16'h0000, r_data[23:16]};
                end
                default: begin
                    w_wr      = 1'b1;
                    w_word    = {r_data, r_stash[7:0]};
                    w_eol     = w_last_pix;
                    w_stash_d = '0;
                end
            endcase
        end else if (w_line_end) begin
            w_phase_d = 2'd0;
            w_stash_d = '0;
            if (r_phase != 2'd0) begin
                w_wr   = 1'b1;
                w_eol  = 1'b1;
                w_word = {8'h00, r_stash};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_phase      <= 2'd0;
            r_stash      <= '0;
            r_sof_arm    <= 1'b0;
            r_overflow   <= 1'b0;
            r_px_cnt     <= '0;
            r_line_cnt   <= '0;
            r_line_width <= '0;
            r_line_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_status) begin
                r_overflow <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    r_phase <= 2'd0;
                    r_stash <= '0;
                    if (w_vs_rise && i_enable) begin
                        r_state    <= StActive;
                        r_sof_arm  <= 1'b1;
                        r_px_cnt   <= '0;
                        r_line_cnt <= '0;
                    end
                end
                default: begin
                    r_phase <= w_phase_d;
                    r_stash <= w_stash_d;
                    if (w_wr) r_sof_arm <= 1'b0;
                    if (w_pix) r_px_cnt <= w_px_cnt_inc;
                    if (w_line_end) begin
                        r_line_width <= r_px_cnt;
                        r_px_cnt     <= '0;
                        r_line_cnt   <= w_line_cnt_inc;
                    end
                    if (w_vs_fall) begin
                        r_state      <= StIdle;
                        r_line_count <= w_line_end ? w_line_cnt_inc : r_line_cnt;
                    end
                end
            endcase
        end
    end

    // A read in the same cycle frees the slot, so a write into a full FIFO still succeeds.
    assign w_rd   = (r_count != '0) && i_out_ready;
    assign w_full = (r_count == DEPTH_W);
    assign w_push = w_wr && (!w_full || w_rd);
    assign w_drop = w_wr && w_full && !w_rd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_rd})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_sof_arm, w_eol, w_word};
    end

    assign o_out_valid = (r_count != '0);
    assign {o_out_sof, o_out_eol, o_out_data} = o_out_valid ? r_mem[r_rd_ptr] : 34'd0;
    assign o_busy       = (r_state == StActive);
    assign o_overflow   = r_overflow;
    assign o_line_width = r_line_width;
    assign o_line_count = r_line_count;

endmodule

// File: tb/tb_hdmi_pixel_packer.sv
// Directed bench for hdmi_pixel_packer: expected words come from a byte-stream packing model
// plus hand-computed constants.
module tb_hdmi_pixel_packer;
    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n, enable, clr, vs, hs, de, rdy;
    logic [23:0] data;
    logic [31:0] o_out_data;
    logic        o_out_valid, o_out_sof, o_out_eol, o_busy, o_overflow;
    logic [11:0] o_line_width, o_line_count;

    rec_t got_q[$];
    rec_t exp_q[$];
    bit   exp_sof;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hdmi_pixel_packer #(
        .FIFO_DEPTH    (16),
        .MAX_WIDTH_BITS(12)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_clr_status (clr),
        .i_hdmi_data  (data),
        .i_hdmi_hs    (hs),
        .i_hdmi_vs    (vs),
        .i_hdmi_de    (de),
        .o_out_data   (o_out_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (rdy),
        .o_out_sof    (o_out_sof),
        .o_out_eol    (o_out_eol),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_line_width (o_line_width),
        .o_line_count (o_line_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] pix(input logic [7:0] seed, input int i);
        logic [7:0] b;
        b = i[7:0];
        return {seed, b, b};
    endfunction

    // Reference: pixels as a little-endian byte stream cut into 32-bit words, zero padded.
    task automatic model_line(input int n, input logic [7:0] seed);
        logic [7:0]  b[$];
        logic [23:0] p;
        rec_t        r;
        int          nw;
        for (int i = 0; i < n; i++) begin
            p = pix(seed, i);
            b.push_back(p[7:0]);
            b.push_back(p[15:8]);
            b.push_back(p[23:16]);
        end
        nw = (b.size() + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            r = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < b.size()) r.data[8*j +: 8] = b[4*k+j];
            end
            r.sof   = exp_sof;
            exp_sof = 1'b0;
            r.eol   = (k == nw - 1);
            exp_q.push_back(r);
        end
    endtask

    // Called at a falling edge: apply inputs for one cycle and log any word consumed at the
    // coming rising edge (DUT outputs only change on the rising edge).
    task automatic step(input logic v, input logic d_en, input logic [23:0] px);
        vs   = v;
        de   = d_en;
        hs   = ~d_en;
        data = px;
        if (o_out_valid && rdy) got_q.push_back({o_out_sof, o_out_eol, o_out_data});
        @(negedge clk);
    endtask

    task automatic vs_on();
        repeat (3) step(1'b1, 1'b0, 24'h0);
    endtask

    task automatic vs_off();
        repeat (4) step(1'b0, 1'b0, 24'h0);
    endtask

    task automatic send_line(input int n, input logic [7:0] seed, input bit expect_it);
        if (expect_it) model_line(n, seed);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, pix(seed, i));
        repeat (3) step(1'b1, 1'b0, 24'h0);
    endtask

    task automatic cmp_words(input string tag, input int n);
        rec_t g;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            g = (k < got_q.size()) ? got_q[k] : '0;
            chk(tag, 64'(g), 64'(exp_q[k]));
        end
    endtask

    task automatic new_test();
        got_q.delete();
        exp_q.delete();
        exp_sof = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; clr = 1'b0; rdy = 1'b1;
        vs = 1'b0; de = 1'b0; hs = 1'b1; data = 24'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(o_out_valid), 64'd0);
        chk("rst_data", 64'(o_out_data), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
        chk("rst_width", 64'(o_line_width), 64'd0);
        chk("rst_count", 64'(o_line_count), 64'd0);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 24'h0);

        // Two lines of 8 px, pixel n = 24'h000100*n + n.
        new_test();
        vs_on();
        send_line(8, 8'h00, 1'b1);
        send_line(8, 8'h00, 1'b1);
        vs_off();
        repeat (4) step(1'b0, 1'b0, 24'h0);
        cmp_words("t1", 12);
        chk("t1_w0", 64'(got_q[0].data), 64'h0100_0000);
        chk("t1_w0_sof", 64'(got_q[0].sof), 64'd1);
        chk("t1_w1", 64'(got_q[1].data), 64'h0202_0001);
        chk("t1_w2", 64'(got_q[2].data), 64'h0003_0300);
        chk("t1_w5_eol", 64'(got_q[5].eol), 64'd1);
        chk("t1_w11_eol", 64'(got_q[11].eol), 64'd1);
        chk("t1_width", 64'(o_line_width), 64'd8);
        chk("t1_lines", 64'(o_line_count), 64'd2);

        // 5 px line flushes a partial word; 1 px line gives one padded word.
        new_test();
        vs_on();
        send_line(5, 8'h10, 1'b1);
        send_line(1, 8'hAB, 1'b1);
        vs_off();
        repeat (4) step(1'b0, 1'b0, 24'h0);
        cmp_words("t2", 5);
        chk("t2_last5", 64'(got_q[3]), {30'd0, 1'b0, 1'b1, 32'h0010_0404});
        chk("t2_one_px", 64'(got_q[4]), {30'd0, 1'b0, 1'b1, 32'h00AB_0000});
        chk("t2_width", 64'(o_line_width), 64'd1);

        // Overflow: 24 px (18 words) into a 16-deep FIFO with no reads.
        new_test();
        rdy = 1'b0;
        vs_on();
        send_line(24, 8'h20, 1'b1);
        vs_off();
        chk("t3_ovf_set", 64'(o_overflow), 64'd1);
        chk("t3_width", 64'(o_line_width), 64'd24);
        clr = 1'b1;
        step(1'b0, 1'b0, 24'h0);
        clr = 1'b0;
        chk("t3_ovf_clr", 64'(o_overflow), 64'd0);
        rdy = 1'b1;
        repeat (20) step(1'b0, 1'b0, 24'h0);
        cmp_words("t3", 16);
        chk("t3_ovf_after", 64'(o_overflow), 64'd0);

        // enable=0 at vs rise ignores the frame; dropping enable mid-frame finishes it.
        new_test();
        enable = 1'b0;
        vs_on();
        chk("t4_busy_off", 64'(o_busy), 64'd0);
        send_line(4, 8'h3F, 1'b0);
        vs_off();
        chk("t4_no_words", 64'(got_q.size()), 64'd0);
        enable = 1'b1;
        vs_on();
        chk("t4_busy_on", 64'(o_busy), 64'd1);
        send_line(4, 8'h40, 1'b1);
        enable = 1'b0;
        send_line(4, 8'h41, 1'b1);
        vs_off();
        chk("t4_busy_end", 64'(o_busy), 64'd0);
        vs_on();
        send_line(4, 8'h42, 1'b0);
        vs_off();
        repeat (4) step(1'b0, 1'b0, 24'h0);
        cmp_words("t4", 6);

        // Reset at px 3 of line 1; capture restarts only at the next vs rise.
        new_test();
        enable = 1'b1;
        vs_on();
        send_line(4, 8'h50, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, pix(8'h51, i));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(o_out_valid), 64'd0);
        chk("t5_rst_data", 64'(o_out_data), 64'd0);
        chk("t5_rst_busy", 64'(o_busy), 64'd0);
        chk("t5_rst_width", 64'(o_line_width), 64'd0);
        chk("t5_rst_count", 64'(o_line_count), 64'd0);
        got_q.delete();
        step(1'b1, 1'b1, pix(8'h51, 3));
        step(1'b1, 1'b1, pix(8'h51, 4));
        rst_n = 1'b1;
        for (int i = 5; i < 8; i++) step(1'b1, 1'b1, pix(8'h51, i));
        repeat (3) step(1'b1, 1'b0, 24'h0);
        chk("t5_busy_after", 64'(o_busy), 64'd0);
        send_line(4, 8'h52, 1'b0);
        vs_off();
        chk("t5_no_stale", 64'(got_q.size()), 64'd0);
        vs_on();
        send_line(3, 8'h53, 1'b1);
        vs_off();
        repeat (4) step(1'b0, 1'b0, 24'h0);
        cmp_words("t5", 3);
        chk("t5_sof", 64'(got_q[0].sof), 64'd1);

        // Fill to 16 words, then read exactly when a word is written, keeping the FIFO full.
        new_test();
        rdy = 1'b0;
        vs_on();
        model_line(90, 8'h60);
        for (int i = 0; i < 92; i++) begin
            rdy = ((i - 1 >= 22) && ((i - 1) % 4 != 0)) || (i >= 90);
            step(1'b1, (i < 90), (i < 90) ? pix(8'h60, i) : 24'h0);
        end
        rdy = 1'b1;
        step(1'b1, 1'b0, 24'h0);
        vs_off();
        repeat (20) step(1'b0, 1'b0, 24'h0);
        chk("t6_ovf", 64'(o_overflow), 64'd0);
        cmp_words("t6", 68);
        chk("t6_last_eol", 64'(got_q[67].eol), 64'd1);
        chk("t6_width", 64'(o_line_width), 64'd90);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
